// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bundle between a bit-stream source and the deserializer.
// Carries timeout_o as well when DESER_TIMEOUT_EN is defined.
interface deserializer_if #(
  parameter int DATA_W = 16,
  parameter int MOD_W  = $clog2(DATA_W)
);
  logic              ser_data_i;
  logic              ser_data_val_i;
  logic              ser_last_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_mod_o;
  logic              deser_data_val_o;
  logic              busy_o;
`ifdef DESER_TIMEOUT_EN
  logic              timeout_o;
`endif

  modport slave (
    input  ser_data_i, ser_data_val_i, ser_last_i,
`ifdef DESER_TIMEOUT_EN
    output timeout_o,
`endif
    output deser_data_o, deser_mod_o, deser_data_val_o, busy_o
  );

  modport master (
    output ser_data_i, ser_data_val_i, ser_last_i,
`ifdef DESER_TIMEOUT_EN
    input  timeout_o,
`endif
    input  deser_data_o, deser_mod_o, deser_data_val_o, busy_o
  );
endinterface

// File: rtl/deserializer.sv
// Reassembles MSB-first serial bits into DATA_W-bit words, with short final words reported via mod.
// Define DESER_TIMEOUT_EN to drop a partial word after TIMEOUT idle cycles and pulse timeout_o.
module deserializer #(
  parameter int DATA_W  = 16,
  parameter int MOD_W   = $clog2(DATA_W),
  parameter int TIMEOUT = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  deserializer_if.slave bus_io
);

  if (DATA_W < 2) begin : g_chk_data_w
    $error("deserializer: DATA_W must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_chk_timeout
    $error("deserializer: TIMEOUT must be >= 1");
  end

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [MOD_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic              val_q, val_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] word_new;
  logic              accept;
  logic              full;

`ifdef DESER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;
`endif

  assign accept = bus_io.ser_data_val_i;
  assign full   = (cnt_q == MOD_W'(DATA_W - 1));

  always_comb begin
    // Bit k of a word lands at index DATA_W-1-k.
    word_new = sreg_q;
    for (int i = 0; i < DATA_W; i++) begin
      if (cnt_q == MOD_W'(DATA_W - 1 - i)) word_new[i] = bus_io.ser_data_i;
    end

    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    mod_d  = mod_q;
    val_d  = 1'b0;

    if (accept) begin
      if (full || bus_io.ser_last_i) begin
        data_d = word_new;
        mod_d  = full ? '0 : cnt_q + MOD_W'(1);
        sreg_d = '0;
        cnt_d  = '0;
        val_d  = 1'b1;
      end else begin
        sreg_d = word_new;
        cnt_d  = cnt_q + MOD_W'(1);
      end
    end

`ifdef DESER_TIMEOUT_EN
    idle_d    = idle_q;
    timeout_d = 1'b0;
    if (accept) begin
      idle_d = '0;
    end else if (busy_q) begin
      // Reaching the limit on this idle cycle discards the partial word.
      if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
        idle_d    = '0;
        sreg_d    = '0;
        cnt_d     = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end
`endif

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      mod_q     <= '0;
      val_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef DESER_TIMEOUT_EN
      idle_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      mod_q     <= mod_d;
      val_q     <= val_d;
      busy_q    <= busy_d;
`ifdef DESER_TIMEOUT_EN
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus_io.deser_data_o     = data_q;
  assign bus_io.deser_mod_o      = mod_q;
  assign bus_io.deser_data_val_o = val_q;
  assign bus_io.busy_o           = busy_q;
`ifdef DESER_TIMEOUT_EN
  assign bus_io.timeout_o        = timeout_q;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench: directed scenarios plus random bit streams against a bit-queue reference model.
// Exercises the timeout path too when DESER_TIMEOUT_EN is defined.
module tb_deserializer;
  localparam int DATA_W  = 16;
  localparam int MOD_W   = $clog2(DATA_W);
  localparam int TIMEOUT = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  deserializer_if #(.DATA_W(DATA_W), .MOD_W(MOD_W)) bus ();

  deserializer #(.DATA_W(DATA_W), .MOD_W(MOD_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus_io (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  bit          bits_q[$];
  logic [15:0] exp_data = '0;
  int          exp_mod  = 0;
  bit          exp_val  = 1'b0;
  int          idle_cnt = 0;
  bit          exp_to   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits_q.delete();
    exp_data = '0;
    exp_mod  = 0;
    exp_val  = 1'b0;
    idle_cnt = 0;
    exp_to   = 1'b0;
  endtask

  // Effect of one rising edge given the inputs held during the preceding cycle.
  task automatic model_edge(input bit v, input bit b, input bit l);
    logic [15:0] w;
    exp_val = 1'b0;
    exp_to  = 1'b0;
    if (v) begin
      bits_q.push_back(b);
      idle_cnt = 0;
      if (bits_q.size() == DATA_W || l) begin
        w = '0;
        for (int k = 0; k < bits_q.size(); k++) w[DATA_W-1-k] = bits_q[k];
        exp_data = w;
        exp_mod  = bits_q.size() % DATA_W;
        exp_val  = 1'b1;
        bits_q.delete();
      end
    end
`ifdef DESER_TIMEOUT_EN
    else if (bits_q.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TIMEOUT) begin
        bits_q.delete();
        idle_cnt = 0;
        exp_to   = 1'b1;
      end
    end
`endif
  endtask

  task automatic check_outputs();
    check("val",  {31'b0, bus.deser_data_val_o}, {31'b0, exp_val});
    check("data", {16'b0, bus.deser_data_o}, {16'b0, exp_data});
    check("mod",  {28'b0, bus.deser_mod_o}, exp_mod);
    check("busy", {31'b0, bus.busy_o}, {31'b0, bits_q.size() != 0});
`ifdef DESER_TIMEOUT_EN
    check("timeout", {31'b0, bus.timeout_o}, {31'b0, exp_to});
`endif
  endtask

  task automatic step(input bit v, input bit b, input bit l);
    bus.ser_data_val_i = v;
    bus.ser_data_i     = b;
    bus.ser_last_i     = l;
    @(posedge clk_i);
    model_edge(v, b, l);
    #1;
    check_outputs();
  endtask

  task automatic send_bits(input logic [15:0] w, input int first, input int n,
                           input bit last, input int gap);
    for (int k = 0; k < n; k++) begin
      step(1'b1, w[DATA_W-1-first-k], last && (k == n - 1));
      if (k != n - 1) repeat (gap) step(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset();
    bus.ser_data_val_i = 1'b0;
    bus.ser_last_i     = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    model_reset();
    check("rst_data", {16'b0, bus.deser_data_o}, 32'h0);
    check("rst_busy", {31'b0, bus.busy_o}, 32'h0);
    check("rst_val",  {31'b0, bus.deser_data_val_o}, 32'h0);
    @(posedge clk_i);
    #3 rst_i = 1'b0;
  endtask

  initial begin
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    bus.ser_last_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;
    model_reset();
    #1 check_outputs();

    // full word, consecutive bits
    send_bits(16'hA5C3, 0, 16, 1'b0, 0);
    check("t1_data", {16'b0, bus.deser_data_o}, 32'hA5C3);
    check("t1_mod",  {28'b0, bus.deser_mod_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("t1_pulse_end", {31'b0, bus.deser_data_val_o}, 32'h0);

    // short word terminated by last
    send_bits(16'hB800, 0, 5, 1'b1, 0);
    check("t2_data", {16'b0, bus.deser_data_o}, 32'hB800);
    check("t2_mod",  {28'b0, bus.deser_mod_o}, 32'd5);
    step(1'b0, 1'b0, 1'b0);

    // back-to-back words
    send_bits(16'hFFFF, 0, 16, 1'b0, 0);
    check("t3_first", {16'b0, bus.deser_data_o}, 32'hFFFF);
    send_bits(16'h0001, 0, 16, 1'b0, 0);
    check("t3_second", {16'b0, bus.deser_data_o}, 32'h0001);
    check("t3_val", {31'b0, bus.deser_data_val_o}, 32'h1);

    // gapped bits, last without valid is ignored
    send_bits(16'h1234, 0, 8, 1'b0, 3);
    step(1'b0, 1'b0, 1'b1);
    check("t4_noval", {31'b0, bus.deser_data_val_o}, 32'h0);
    send_bits(16'h1234, 8, 8, 1'b0, 0);
    check("t4_data", {16'b0, bus.deser_data_o}, 32'h1234);
    check("t4_mod",  {28'b0, bus.deser_mod_o}, 32'd0);

    // last on the final bit of a full word gives one completion
    send_bits(16'h8001, 0, 16, 1'b1, 0);
    check("t_lastfull_mod", {28'b0, bus.deser_mod_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0);

    // reset mid-word
    send_bits(16'hFFFF, 0, 7, 1'b0, 0);
    async_reset();
    step(1'b0, 1'b0, 1'b0);
    send_bits(16'hBEEF, 0, 16, 1'b0, 0);
    check("t5_data", {16'b0, bus.deser_data_o}, 32'hBEEF);
    step(1'b0, 1'b0, 1'b0);

`ifdef DESER_TIMEOUT_EN
    send_bits(16'hE000, 0, 3, 1'b0, 0);
    repeat (TIMEOUT) step(1'b0, 1'b0, 1'b0);
    check("t6_timeout", {31'b0, bus.timeout_o}, 32'h1);
    check("t6_busy", {31'b0, bus.busy_o}, 32'h0);
    step(1'b0, 1'b0, 1'b0);
    send_bits(16'h00FF, 0, 16, 1'b0, 0);
    check("t6_data", {16'b0, bus.deser_data_o}, 32'h00FF);
    // bit arriving on the would-be limit cycle keeps the word alive
    send_bits(16'hC000, 0, 2, 1'b0, 0);
    repeat (TIMEOUT - 1) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t6_alive", {31'b0, bus.busy_o}, 32'h1);
    step(1'b0, 1'b0, 1'b1);
`endif

    // random streams with occasional long idle gaps
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 249) begin
        repeat (TIMEOUT + 2) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 19) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
